// File: rtl/fc1_wstream_fifo.sv
// FC1 weight-stream buffer: queues host weight groups and presents one group
// to fcn per fc1_next request, with pass tracking and sticky error flags.
module fc1_wstream_fifo #(
  parameter int NUM_PE       = 4,
  parameter int DEPTH        = 16,
  parameter int TOTAL_GROUPS = 330
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [NUM_PE*8-1:0]        push_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       next,
  output logic signed [NUM_PE*8-1:0] w_stream,
  output logic                       w_valid,
  output logic [15:0]                group_cnt,
  output logic                       last_group,
  output logic                       stream_done,
  output logic                       ovf_err,
  output logic                       udf_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = NUM_PE * 8;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
  localparam logic [15:0] LAST_CNT  = TOTAL_GROUPS[15:0];

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_STARVE, S_DONE} state_t;

  logic [GW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          cnt_q, cnt_d;
  state_t               state_q, state_d;
  logic signed [GW-1:0] w_stream_q;
  logic                 w_valid_q, last_q, done_q, ovf_q, udf_q;
  logic [15:0]          grp_q, grp_d;
  logic                 do_push, do_pop, ovf_set, udf_set;

  assign full        = (cnt_q == DEPTH_CNT);
  assign empty       = (cnt_q == '0);
  assign level       = cnt_q;
  assign w_stream    = w_stream_q;
  assign w_valid     = w_valid_q;
  assign group_cnt   = grp_q;
  assign last_group  = last_q;
  assign stream_done = done_q;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
  always_comb begin
    do_push = push && !full && !clear;
    ovf_set = push && full && !clear;
    do_pop  = 1'b0;
    udf_set = 1'b0;
    state_d = state_q;
    if (!clear) begin
      case (state_q)
        S_IDLE, S_STARVE: begin
          udf_set = next;
          if (!empty) begin
            do_pop  = 1'b1;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (next) begin
            if (last_q)       state_d = S_DONE;
            else if (!empty)  do_pop  = 1'b1;
            else              state_d = S_STARVE;
          end
        end
        S_DONE:  udf_set = next;
        default: state_d = S_IDLE;
      endcase
    end
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    grp_d = grp_q + {15'd0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      w_stream_q <= '0;
      w_valid_q  <= 1'b0;
      grp_q      <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else if (clear) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      w_stream_q <= '0;
      w_valid_q  <= 1'b0;
      grp_q      <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_valid_q <= do_pop;
      grp_q     <= grp_d;
      last_q    <= (state_d == S_HOLD) && (grp_d == LAST_CNT);
      done_q    <= (state_d == S_DONE);
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        w_stream_q <= mem_q[rd_ptr_q];
      end
    end
  end
endmodule

// File: tb/tb_fc1_wstream_fifo.sv
// Scoreboard bench: two instances (long pass and 6-group pass) share stimulus and
// are compared against a queue-based model of the weight-stream behaviour.
module tb_fc1_wstream_fifo;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst, clear, push, next;
  logic [31:0] push_data;
  logic full [2], empty [2], w_valid [2], last_group [2];
  logic stream_done [2], ovf_err [2], udf_err [2];
  logic [2:0] level [2];
  logic signed [31:0] w_stream [2];
  logic [15:0] group_cnt [2];

  always #5 clk = ~clk;

  fc1_wstream_fifo #(.NUM_PE(4), .DEPTH(DEP), .TOTAL_GROUPS(330)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .push_data(push_data),
    .full(full[0]), .empty(empty[0]), .level(level[0]), .next(next),
    .w_stream(w_stream[0]), .w_valid(w_valid[0]), .group_cnt(group_cnt[0]),
    .last_group(last_group[0]), .stream_done(stream_done[0]),
    .ovf_err(ovf_err[0]), .udf_err(udf_err[0]));

  fc1_wstream_fifo #(.NUM_PE(4), .DEPTH(DEP), .TOTAL_GROUPS(6)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .push_data(push_data),
    .full(full[1]), .empty(empty[1]), .level(level[1]), .next(next),
    .w_stream(w_stream[1]), .w_valid(w_valid[1]), .group_cnt(group_cnt[1]),
    .last_group(last_group[1]), .stream_done(stream_done[1]),
    .ovf_err(ovf_err[1]), .udf_err(udf_err[1]));

  typedef struct {
    logic [31:0] d;
    int          cnt;
  } exp_t;

  logic [31:0] mq [2][$];
  exp_t        eq [2][$];
  bit          m_pres [2], m_done [2], m_ovf [2], m_udf [2];
  int          m_cnt [2], last_loads [2];
  logic [31:0] m_ws [2];
  int          checks = 0;
  int          errors = 0;

  function automatic int tot(input int i);
    return (i == 0) ? 330 : 6;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got 0x%0h want 0x%0h", nm, i, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      eq[i].delete();
      m_pres[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
      m_cnt[i] = 0; last_loads[i] = 0; m_ws[i] = '0;
    end
  endtask

  task automatic load(input int i);
    exp_t e;
    m_ws[i] = mq[i].pop_front();
    m_cnt[i]++;
    m_pres[i] = 1;
    last_loads[i] = 1;
    e.d = m_ws[i];
    e.cnt = m_cnt[i];
    eq[i].push_back(e);
  endtask

  // One clock of the reference: decisions use the state seen before the edge.
  task automatic model_step(input bit p, input logic [31:0] d, input bit n, input bit c);
    for (int i = 0; i < 2; i++) begin
      bit was_full, was_empty;
      last_loads[i] = 0;
      if (c) begin
        mq[i].delete(); eq[i].delete();
        m_pres[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
        m_cnt[i] = 0; m_ws[i] = '0;
      end else begin
        was_full  = (mq[i].size() == DEP);
        was_empty = (mq[i].size() == 0);
        if (n && (m_done[i] || !m_pres[i])) m_udf[i] = 1;
        if (!m_done[i]) begin
          if (!m_pres[i]) begin
            if (!was_empty) load(i);
          end else if (n) begin
            if (m_cnt[i] == tot(i)) m_done[i] = 1;
            else if (!was_empty)    load(i);
            else                    m_pres[i] = 0;
          end
        end
        if (p) begin
          if (was_full) m_ovf[i] = 1;
          else          mq[i].push_back(d);
        end
      end
    end
  endtask

  task automatic step(input bit p, input logic [31:0] d, input bit n, input bit c);
    @(negedge clk);
    push = p; push_data = d; next = n; clear = c;
    @(posedge clk);
    model_step(p, d, n, c);
    #1;
    push = 1'b0; next = 1'b0; clear = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, ".level"}, i, 32'(level[i]), 32'(mq[i].size()));
      chk({tag, ".full"}, i, 32'(full[i]), 32'(mq[i].size() == DEP));
      chk({tag, ".empty"}, i, 32'(empty[i]), 32'(mq[i].size() == 0));
      chk({tag, ".group_cnt"}, i, 32'(group_cnt[i]), 32'(m_cnt[i]));
      chk({tag, ".last_group"}, i, 32'(last_group[i]),
          32'(m_pres[i] && !m_done[i] && (m_cnt[i] == tot(i))));
      chk({tag, ".stream_done"}, i, 32'(stream_done[i]), 32'(m_done[i]));
      chk({tag, ".ovf_err"}, i, 32'(ovf_err[i]), 32'(m_ovf[i]));
      chk({tag, ".udf_err"}, i, 32'(udf_err[i]), 32'(m_udf[i]));
      chk({tag, ".w_stream"}, i, w_stream[i], m_ws[i]);
      chk({tag, ".w_valid"}, i, 32'(w_valid[i]), 32'(last_loads[i]));
      chk({tag, ".pending"}, i, 32'(eq[i].size()), 32'(last_loads[i]));
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (w_valid[i] === 1'b1) begin
          if (eq[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w_valid_unexpected inst%0d got w_stream 0x%0h want no load", i, w_stream[i]);
          end else begin
            mon_e = eq[i].pop_front();
            chk("load.w_stream", i, w_stream[i], mon_e.d);
            chk("load.group_cnt", i, 32'(group_cnt[i]), 32'(mon_e.cnt));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; push = 1'b0; next = 1'b0; push_data = '0;
    model_reset();
    #22;
    check_state("reset");
    #1 rst = 1'b0;

    // single group auto-load
    step(1, 32'h04030201, 0, 0);
    check_state("push1");
    step(0, 0, 0, 0);
    check_state("load1");
    step(0, 0, 0, 0);
    check_state("idle1");

    // fill to full, then overflow
    step(0, 0, 0, 1);
    for (int k = 0; k < DEP + 1; k++) step(1, $urandom, 0, 0);
    check_state("fill");
    step(1, 32'hDEADBEEF, 0, 0);
    check_state("ovf");
    for (int k = 0; k < DEP + 3; k++) step(0, 0, 1, 0);
    check_state("drain");

    // starvation
    step(0, 0, 0, 1);
    step(1, $urandom, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check_state("starve");
    step(0, 0, 1, 0);
    check_state("udf");
    step(1, 32'h80FF7F00, 0, 0);
    step(0, 0, 0, 0);
    check_state("starve_load");

    // random full pass
    step(0, 0, 0, 1);
    for (int k = 0; k < 400 && !m_done[1]; k++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 0);
      if (k % 16 == 0) check_state("rand");
    end
    for (int k = 0; k < 60 && !m_done[1]; k++) step(1'(mq[1].size() < DEP), $urandom, 1, 0);
    check_state("pass_done");
    step(0, 0, 1, 0);
    check_state("after_done");

    // pointer wrap with simultaneous push and pop
    step(0, 0, 0, 1);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 0);
    for (int k = 0; k < 3 * DEP; k++) begin
      step(1, $urandom, 1, 0);
      check_state("wrap");
    end

    // clear with push and next
    step(0, 0, 0, 1);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 1, 1);
    check_state("clear");
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_state("post_clear");

    // asynchronous reset mid-pass
    step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 1, 0);
    #1 rst = 1'b1;
    #1 model_reset();
    check_state("arst");
    #1 rst = 1'b0;
    step(1, 32'h11223344, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_state("post_arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc1_wstream_fifo.md
# fc1_wstream_fifo

Buffered FC1 weight-stream stage between the host write port and the `fcn` block's `fc1_w` / `fc1_next` interface. The host pushes 32-bit words, each holding one int8 weight per PE. The block queues them and presents one weight group per `fcn` request, so the host need not write in lock-step with each `fc1_next`. It tracks how many groups have been delivered in a pass, and raises sticky error flags on overflow and underflow.

## Interface
Parameters:
- NUM_PE, 4, number of PE lanes; one signed 8-bit weight per lane per group
- DEPTH, 16, FIFO depth in groups; must be a power of two, ≥2
- TOTAL_GROUPS, 330, groups per FC1 pass (IN1_N·OUT1_M/NUM_PE)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush: FIFO, counters, errors, FSM
- push  in  1  host write strobe, one group per cycle
- push_data  in  NUM_PE*8  lane p = push_data[8p+7:8p]; byte 0 → PE0
- full  out  1  FIFO holds DEPTH groups
- empty  out  1  FIFO holds 0 groups
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- next  in  1  one-cycle request from fcn to advance to the next group
- w_stream  out  NUM_PE×8 signed  currently presented group; registered
- w_valid  out  1  one-cycle pulse when a new group is loaded into w_stream
- group_cnt  out  16  groups presented since clear
- last_group  out  1  presented group is index TOTAL_GROUPS-1
- stream_done  out  1  last group consumed; held until clear
- ovf_err  out  1  sticky: push while full
- udf_err  out  1  sticky: next with no group presented

## Operation
- FIFO: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; level is derived from a separate counter.
- FSM states:
  - S_IDLE (nothing presented): if FIFO is non-empty, pop and load w_stream, go to S_HOLD.
  - S_HOLD (group presented): on next, if last_group go to S_DONE with no pop; else if FIFO is non-empty, pop and load, stay in S_HOLD; else go to S_STARVE.
  - S_STARVE (request pending, FIFO empty): when FIFO becomes non-empty, pop and load, go to S_HOLD.
  - S_DONE: stream_done=1; w_stream holds the last group; pushes are still accepted.
- Each load: w_stream ← FIFO head, w_valid pulses, group_cnt increments. last_group = (group_cnt == TOTAL_GROUPS) while in S_HOLD.
- Push while full: the word is dropped, ovf_err is set, and FIFO state is unchanged.
- next in S_IDLE, S_STARVE, or S_DONE: ignored; udf_err is set.
- Simultaneous push and pop with the FIFO non-empty and not full: both happen and level is unchanged. Push while full with a pop in the same cycle: the push is still dropped (full is evaluated before the pop).
- clear: empties the FIFO, resets group_cnt, errors, and w_stream to 0, and sends the FSM to S_IDLE. It has priority over push and next in the same cycle.

## Timing
- Reset values: w_stream=0, w_valid=0, group_cnt=0, last_group=0, stream_done=0, ovf_err=0, udf_err=0, full=0, empty=1, level=0, FSM in S_IDLE.
- Push at edge t: level, empty, and full update at t+1.
- There is no fall-through. The earliest load is the edge after the data is visible in the FIFO.
  - Push at t into an empty FIFO in S_IDLE: load at t+1 edge, so w_stream and w_valid are visible in the cycle after t+1.
- next sampled at edge t in S_HOLD with data available: new w_stream and w_valid appear after edge t; one-cycle request-to-data latency.
- In S_STARVE, a push at t gives a load at t+1.
- Sustained throughput: one group per cycle when next is asserted every cycle and the FIFO stays non-empty.
- An asynchronous rst mid-pass aborts the pass; all outputs return to reset values immediately.

## Test plan
- Reset, then push 0x04030201 → FIFO load at next edge, then w_stream = {1,2,3,4}, w_valid pulses once, group_cnt=1, level returns to 0.
- Fill: push DEPTH+1 words with no next; the first is auto-loaded, so level=DEPTH, full=1 and ovf_err stays 0; push one more → ovf_err=1 and that word is lost (confirm via the popped sequence).
- Starvation: with a group presented and the FIFO empty, pulse next → no w_valid, FSM in S_STARVE; a second next → udf_err=1; push 0x80FF7F00 → w_stream = {0,127,-1,-128} one cycle later.
- Full pass with TOTAL_GROUPS=6, DEPTH=4: a random push/next interleave delivers groups in order. The next on group 6 → stream_done=1, group_cnt=6, w_stream unchanged; a further next → udf_err=1.
- Pointer wrap: 3·DEPTH pushes and pops with simultaneous push and pop → data in order, level never exceeds DEPTH, no errors.
- clear asserted together with push and next mid-pass → level=0, group_cnt=0, errors=0, w_stream=0, S_IDLE; the pushed word is discarded.
